// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   - Default NOP encoding and reset fetch address.
//   - FSM state encoding for the request/response tracker.
//   - Queue entry layout {instr, pc, pc+4} and a word-alignment helper.
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,  // may issue a request
    ST_WAIT    = 2'd1,  // one live request outstanding
    ST_DISCARD = 2'd2   // one stale request outstanding, its data is dropped
  } fq_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_next;
  } fq_entry_t;

  localparam fq_entry_t ENTRY_ZERO = '{instr: 32'h0, pc: 32'h0, pc_next: 32'h0};

  // Clear the byte offset of a fetch target.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH x 96-bit FIFO holding fetched {instr, pc, pc+4} entries.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_flush         empties the queue (wins over push/pop)
//   i_push          write i_push_data at the tail (ignored when full)
//   i_pop           drop the head entry (ignored when empty)
//   o_count         number of valid entries, 0..DEPTH
//   o_head          entry at the head (meaningful only when o_count != 0)
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fq_entry_t              i_push_data,
  input  logic                   i_pop,
  output logic [$clog2(DEPTH):0] o_count,
  output fq_entry_t              o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_C    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   EMPTY_C   = (AW+1)'(1'b0);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);

  fq_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  // Qualify push/pop against the current occupancy.
  always_comb begin
    w_push_ok = i_push && (r_count != FULL_C);
    w_pop_ok  = i_pop && (r_count != EMPTY_C);
  end

  // Pointer and occupancy bookkeeping; flush returns to the empty state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= AW'(1'b0);
      r_wr_ptr <= AW'(1'b0);
      r_count  <= EMPTY_C;
    end else if (i_flush) begin
      r_rd_ptr <= AW'(1'b0);
      r_wr_ptr <= AW'(1'b0);
      r_count  <= EMPTY_C;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= ENTRY_ZERO;
      end
    end else if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage between a handshaked instruction memory and IF_ID.
// Issues sequential word-aligned fetches with at most one request in flight,
// buffers responses in a fetch_fifo and presents the head to IF_ID.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_redirect_valid      taken branch/jump from ID: flush and refetch
//   i_redirect_pc         redirect target (byte offset ignored)
//   i_id_hold             IF_ID hold; the head is not consumed
//   o_imem_req/o_imem_addr, i_imem_ready   request handshake
//   i_imem_rvalid/i_imem_rdata             response
//   o_if_valid, o_if_instr, o_if_pc, o_if_pc_next   head entry view
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_id_hold,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc_next
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);

  fq_state_e     r_state;
  fq_state_e     w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   r_resp_pc;
  logic          r_active;
  logic          w_pc_adv;
  logic          w_req;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_if_valid;
  logic [CW-1:0] w_count;
  fq_entry_t     w_head;
  fq_entry_t     w_push_data;

  // Handshake qualifiers. A request is only made while a queue slot is free,
  // so the eventual response always has room. r_active keeps the request
  // low while reset is asserted; fetching begins the cycle after release.
  always_comb begin
    w_req      = r_active && (r_state == ST_FETCH) && (w_count < DEPTH_C);
    w_accept   = w_req && i_imem_ready;
    w_if_valid = (w_count != CNT_ZERO) && !i_redirect_valid;
    w_pop      = w_if_valid && !i_id_hold;
  end

  // Next-state, push decision and next fetch address.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pc_adv    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (w_accept) begin
          // A request accepted alongside a redirect is already stale.
          w_state_nxt = i_redirect_valid ? ST_DISCARD : ST_WAIT;
          w_pc_adv    = 1'b1;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (i_imem_rvalid) begin
          w_state_nxt = ST_FETCH;
          w_push      = !i_redirect_valid;
        end else if (i_redirect_valid) begin
          w_state_nxt = ST_DISCARD;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DISCARD: begin
        if (i_imem_rvalid) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_DISCARD;
        end
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
    // Redirect target replaces the +4 advance outright.
    if (i_redirect_valid) begin
      w_fetch_pc_nxt = word_align(i_redirect_pc);
    end else if (w_pc_adv) begin
      w_fetch_pc_nxt = r_fetch_pc + 32'd4;
    end else begin
      w_fetch_pc_nxt = r_fetch_pc;
    end
  end

  // FSM, fetch address and the address of the request in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= 32'h0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_active   <= 1'b1;
      if (w_accept) begin
        r_resp_pc <= r_fetch_pc;
      end
    end
  end

  assign w_push_data = '{instr: i_imem_rdata, pc: r_resp_pc, pc_next: r_resp_pc + 32'd4};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  // Output view of the head; a bubble shows NOP with zero addresses.
  always_comb begin
    o_imem_req  = w_req;
    o_imem_addr = r_fetch_pc;
    o_if_valid  = w_if_valid;
    if (w_if_valid) begin
      o_if_instr   = w_head.instr;
      o_if_pc      = w_head.pc;
      o_if_pc_next = w_head.pc_next;
    end else begin
      o_if_instr   = NOP_INSTR;
      o_if_pc      = 32'h0;
      o_if_pc_next = 32'h0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: responder memory, queue-level
// reference model compared every cycle, and directed literal checks.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_hold = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_next;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_queue #(
    .DEPTH     (DEPTH),
    .RESET_PC  (32'h0),
    .NOP_INSTR (NOP)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_id_hold        (id_hold),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_ready     (imem_ready),
    .i_imem_rvalid    (imem_rvalid),
    .i_imem_rdata     (imem_rdata),
    .o_if_valid       (if_valid),
    .o_if_instr       (if_instr),
    .o_if_pc          (if_pc),
    .o_if_pc_next     (if_pc_next)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction word the memory returns for an address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // ---------------- memory responder ----------------
  int          cfg_lat_min = 1;
  int          cfg_lat_max = 1;
  bit          cfg_rand_ready = 1'b0;
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (imem_req && imem_ready) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = int'($urandom_range(cfg_lat_max, cfg_lat_min));
      end
      #1;
      imem_rvalid = 1'b0;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt <= 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = instr_of(mem_addr);
          mem_busy    = 1'b0;
        end
      end
      imem_ready = mem_busy ? 1'b0 : (cfg_rand_ready ? 1'($urandom_range(1, 0)) : 1'b1);
    end
  end

  // ---------------- reference model ----------------
  // Queue of fetched pcs plus a record of the single outstanding request.
  logic [31:0] mq[$];
  logic [31:0] m_fetch_pc = 32'h0;
  logic [31:0] m_out_pc = 32'h0;
  bit          m_out = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_started = 1'b0;
  bit          m_acc;

  function automatic bit exp_req();
    return m_started && !m_out && (mq.size() < DEPTH);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_fetch_pc = 32'h0;
        m_out      = 1'b0;
        m_stale    = 1'b0;
        m_started  = 1'b0;
      end else begin
        m_acc = exp_req() && imem_ready;
        if (redirect_valid) begin
          mq.delete();
          if (m_out && imem_rvalid) m_out = 1'b0;
          else if (m_out) m_stale = 1'b1;
          if (m_acc) begin
            m_out   = 1'b1;
            m_stale = 1'b1;
          end
          m_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
          if (mq.size() > 0 && !id_hold) void'(mq.pop_front());
          if (m_out && imem_rvalid) begin
            if (!m_stale) begin
              chk("push_into_full", 32'(mq.size() < DEPTH), 32'h1);
              mq.push_back(m_out_pc);
            end
            m_out = 1'b0;
          end
          if (m_acc) begin
            m_out      = 1'b1;
            m_stale    = 1'b0;
            m_out_pc   = m_fetch_pc;
            m_fetch_pc = m_fetch_pc + 32'd4;
          end
        end
        m_started = 1'b1;
      end
    end
  end

  // Every-cycle compare of all outputs against the model.
  bit v_exp;
  initial begin
    forever begin
      @(negedge clk);
      v_exp = (mq.size() > 0) && !redirect_valid;
      chk("imem_req", 32'(imem_req), 32'(exp_req()));
      chk("imem_addr", imem_addr, m_fetch_pc);
      chk("if_valid", 32'(if_valid), 32'(v_exp));
      chk("if_instr", if_instr, v_exp ? instr_of(mq[0]) : NOP);
      chk("if_pc", if_pc, v_exp ? mq[0] : 32'h0);
      chk("if_pc_next", if_pc_next, v_exp ? mq[0] + 32'd4 : 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
  endtask

  // Advance until a request is being accepted this cycle.
  task automatic wait_acc(input string name, output logic [31:0] a);
    bit ok;
    ok = 1'b0;
    a  = 32'hFFFF_FFFF;
    for (int i = 0; i < 60; i++) begin
      step();
      if (imem_req && imem_ready) begin
        a  = imem_addr;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  logic [31:0] acc_addr[3];
  logic [31:0] exp_drain[4];
  logic [31:0] a;
  int          na;
  bit          seen;
  bit          did_rst;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and first fetch with a 1-cycle memory.
    #2;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_if_instr", if_instr, NOP);
    steps(2);
    rst_n = 1'b1;
    na = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req && imem_ready && na < 3) begin
        acc_addr[na] = imem_addr;
        na++;
      end
      if (if_valid && !seen) begin
        seen = 1'b1;
        chk("t1_first_pc", if_pc, 32'h0);
        chk("t1_first_pc_next", if_pc_next, 32'h4);
        chk("t1_first_instr", if_instr, 32'hDEAD_BEEF);
      end
    end
    chk("t1_seen_valid", 32'(seen), 32'h1);
    chk("t1_addr0", acc_addr[0], 32'h0);
    chk("t1_addr1", acc_addr[1], 32'h4);
    chk("t1_addr2", acc_addr[2], 32'h8);

    // Hold fills the queue, then it drains in order.
    id_hold = 1'b1;
    do_reset();
    steps(12);
    chk("t2_full_req", 32'(imem_req), 32'h0);
    chk("t2_full_valid", 32'(if_valid), 32'h1);
    id_hold = 1'b0;
    exp_drain = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int k = 0; k < 4; k++) begin
      chk("t2_drain_pc", if_pc, exp_drain[k]);
      step();
    end

    // Redirect while waiting on 0x10; the late response is dropped.
    cfg_lat_min = 3;
    cfg_lat_max = 3;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (imem_req && imem_ready && imem_addr == 32'h10) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t3_reach_0x10", 32'(seen), 32'h1);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    chk("t3_redirect_valid0", 32'(if_valid), 32'h0);
    step();
    redirect_valid = 1'b0;
    wait_acc("t3_acc", a);
    chk("t3_next_addr", a, 32'h40);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (if_valid) begin
        seen = 1'b1;
        chk("t3_first_pc", if_pc, 32'h40);
        chk("t3_first_instr", if_instr, 32'hDEAD_BEAF);
        break;
      end
    end
    chk("t3_seen_valid", 32'(seen), 32'h1);

    // Redirect coinciding with rvalid and a pending pop.
    cfg_lat_min = 1;
    cfg_lat_max = 1;
    id_hold = 1'b1;
    do_reset();
    steps(5);
    id_hold = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_rvalid && if_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("t4_found_slot", 32'(seen), 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("t4_valid_forced0", 32'(if_valid), 32'h0);
    chk("t4_instr_nop", if_instr, NOP);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4_empty_after", 32'(if_valid), 32'h0);
    chk("t4_addr", imem_addr, 32'h100);
    chk("t4_req", 32'(imem_req), 32'h1);

    // Alignment of an odd target and wrap past the top of memory.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h7FFF_FFFE;
    step();
    redirect_valid = 1'b0;
    chk("t5_aligned_addr", imem_addr, 32'h7FFF_FFFC);
    wait_acc("t5_acc0", a);
    chk("t5_acc0_addr", a, 32'h7FFF_FFFC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    wait_acc("t5_acc1", a);
    chk("t5_acc1_addr", a, 32'hFFFF_FFFC);
    wait_acc("t5_acc2", a);
    chk("t5_wrap_addr", a, 32'h0);
    steps(4);

    // Random handshake timing, hold, redirects and a reset mid-request.
    cfg_lat_min    = 1;
    cfg_lat_max    = 6;
    cfg_rand_ready = 1'b1;
    did_rst        = 1'b0;
    for (int i = 0; i < 600; i++) begin
      id_hold        = ($urandom_range(2, 0) == 0);
      redirect_valid = ($urandom_range(24, 0) == 0);
      redirect_pc    = $urandom();
      if (!did_rst && i >= 300 && mem_busy) begin
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 32'(imem_req), 32'h0);
        chk("t6_rst_valid", 32'(if_valid), 32'h0);
        chk("t6_rst_instr", if_instr, NOP);
        chk("t6_rst_pc", if_pc, 32'h0);
        chk("t6_rst_pc_next", if_pc_next, 32'h0);
        steps(2);
        rst_n   = 1'b1;
        did_rst = 1'b1;
      end
      step();
    end
    chk("t6_reset_pulsed", 32'(did_rst), 32'h1);
    redirect_valid = 1'b0;
    id_hold        = 1'b0;
    steps(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
